// File: rtl/lsu_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module      : lsu_byte_bridge
// Description : Serialises memory-stage loads/stores onto a byte-wide req/ack
//               bus, stalling the pipeline and extending load results.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_byte_bridge #(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            validM,
  input  logic            memWriteM,
  input  logic            mem2regM,
  input  logic [2:0]      funct3M,
  input  logic [WORD-1:0] ALUResultM,
  input  logic [WORD-1:0] writeDataM,
  output logic            stallM,
  output logic [WORD-1:0] readDataM,
  output logic            bus_req,
  output logic            bus_we,
  output logic [WORD-1:0] bus_addr,
  output logic [7:0]      bus_wdata,
  input  logic            bus_ack,
  input  logic [7:0]      bus_rdata
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_XFER = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      r_idx;
  logic [1:0]      r_lastIdx;
  logic [2:0]      r_funct3;
  logic            r_we;
  logic [WORD-1:0] r_baseAddr;
  logic [WORD-1:0] r_wdata;
  logic [WORD-1:0] r_lanes;
  logic [WORD-1:0] r_readData;

  logic            w_access;
  logic            w_inXfer;
  logic            w_lastAck;
  logic [1:0]      w_lastIdx;
  logic [WORD-1:0] w_lanes;
  logic [WORD-1:0] w_extended;

  // A store wins when both request flags are set.
  assign w_access  = validM & (memWriteM | mem2regM);
  assign w_inXfer  = (r_state == c_XFER);
  assign w_lastAck = w_inXfer & bus_ack & (r_idx == r_lastIdx);

  always_comb begin
    w_lastIdx = 2'd3;
    case (funct3M[1:0])
      2'b00:   w_lastIdx = 2'd0;
      2'b01:   w_lastIdx = 2'd1;
      default: w_lastIdx = 2'd3;
    endcase
  end

  // Lane image including the byte being acknowledged this cycle.
  always_comb begin
    w_lanes = r_lanes;
    w_lanes[{r_idx, 3'b000} +: 8] = bus_rdata;
  end

  always_comb begin
    w_extended = w_lanes;
    case (r_funct3)
      3'b000:  w_extended = {{24{w_lanes[7]}}, w_lanes[7:0]};
      3'b001:  w_extended = {{16{w_lanes[15]}}, w_lanes[15:0]};
      3'b100:  w_extended = {24'd0, w_lanes[7:0]};
      3'b101:  w_extended = {16'd0, w_lanes[15:0]};
      default: w_extended = w_lanes;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_IDLE;
      r_idx      <= 2'd0;
      r_lastIdx  <= 2'd0;
      r_funct3   <= 3'd0;
      r_we       <= 1'b0;
      r_baseAddr <= '0;
      r_wdata    <= '0;
      r_lanes    <= '0;
      r_readData <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_access) begin
            r_baseAddr <= ALUResultM;
            r_wdata    <= writeDataM;
            r_we       <= memWriteM;
            r_lastIdx  <= w_lastIdx;
            r_funct3   <= funct3M;
            r_idx      <= 2'd0;
            r_state    <= c_XFER;
          end
        end
        c_XFER: begin
          if (bus_ack) begin
            if (!r_we) begin
              r_lanes <= w_lanes;
            end
            r_idx <= r_idx + 2'd1;
            if (w_lastAck) begin
              r_state <= c_DONE;
              if (!r_we) begin
                r_readData <= w_extended;
              end
            end
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Gating with reset keeps stall low while reset is held, even if an access is presented.
  assign stallM    = reset & (((r_state == c_IDLE) & w_access) | w_inXfer);
  assign bus_req   = w_inXfer;
  assign bus_we    = r_we;
  assign bus_addr  = r_baseAddr + {{(WORD-2){1'b0}}, r_idx};
  assign bus_wdata = r_wdata[{r_idx, 3'b000} +: 8];
  assign readDataM = r_readData;

endmodule
`default_nettype wire

// File: tb/tb_lsu_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_byte_bridge
// Description : Directed self-checking bench for lsu_byte_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_byte_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        validM, memWriteM, mem2regM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, writeDataM;
  logic        stallM;
  logic [31:0] readDataM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack;
  logic [7:0]  bus_rdata;

  int checks = 0;
  int errors = 0;

  lsu_byte_bridge #(.WORD(32)) dut (
    .clk(clk), .reset(reset),
    .validM(validM), .memWriteM(memWriteM), .mem2regM(mem2regM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .writeDataM(writeDataM),
    .stallM(stallM), .readDataM(readDataM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Runs one access from its IDLE cycle through DONE; entered and left at posedge+1.
  task automatic runAccess(input string tag, input logic we, input logic ld,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rbytes,
                           input int wait0, input int n, input int expStall,
                           input logic [31:0] expRead);
    int stallCnt;
    logic [31:0] expAddr;
    validM = 1'b1; memWriteM = we; mem2regM = ld; funct3M = f3;
    ALUResultM = addr; writeDataM = wdata; bus_ack = 1'b0;
    @(negedge clk);
    chk({tag, " idle_stall"}, {31'd0, stallM}, 32'd1);
    chk({tag, " idle_req"}, {31'd0, bus_req}, 32'd0);
    stallCnt = 1;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      expAddr = addr + k;
      for (int w = 0; w < ((k == 0) ? wait0 : 0); w++) begin
        bus_ack = 1'b0;
        @(negedge clk);
        chk({tag, " wait_req"}, {31'd0, bus_req}, 32'd1);
        chk({tag, " wait_addr"}, bus_addr, expAddr);
        stallCnt += int'(stallM);
        @(posedge clk); #1;
      end
      bus_ack = 1'b1;
      bus_rdata = rbytes[8*k +: 8];
      @(negedge clk);
      chk({tag, " req"}, {31'd0, bus_req}, 32'd1);
      chk({tag, " addr"}, bus_addr, expAddr);
      chk({tag, " we"}, {31'd0, bus_we}, {31'd0, we});
      if (we) chk({tag, " wdata"}, {24'd0, bus_wdata}, {24'd0, wdata[8*k +: 8]});
      stallCnt += int'(stallM);
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    validM = 1'b0; memWriteM = 1'b0; mem2regM = 1'b0;
    @(negedge clk);
    chk({tag, " done_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, " done_stall"}, {31'd0, stallM}, 32'd0);
    chk({tag, " rdata"}, readDataM, expRead);
    stallCnt += int'(stallM);
    chk({tag, " stall_cycles"}, stallCnt, expStall);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; validM = 1'b0; memWriteM = 1'b0; mem2regM = 1'b0;
    funct3M = 3'd0; ALUResultM = '0; writeDataM = '0;
    bus_ack = 1'b0; bus_rdata = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_stall", {31'd0, stallM}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", {24'd0, bus_wdata}, 32'd0);
    chk("rst_rdata", readDataM, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    runAccess("sw", 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'hA1B2_C3D4, 32'd0,
              0, 4, 5, 32'h0000_0000);
    runAccess("lb", 1'b0, 1'b1, 3'b000, 32'h0000_0020, 32'd0, 32'h0000_0080,
              0, 1, 2, 32'hFFFF_FF80);
    runAccess("lbu", 1'b0, 1'b1, 3'b100, 32'h0000_0020, 32'd0, 32'h0000_0080,
              0, 1, 2, 32'h0000_0080);
    runAccess("lh", 1'b0, 1'b1, 3'b001, 32'hFFFF_FFFF, 32'd0, 32'h0000_9234,
              3, 2, 6, 32'hFFFF_9234);
    runAccess("both", 1'b1, 1'b1, 3'b000, 32'h0000_0300, 32'h0000_0055, 32'd0,
              0, 1, 2, 32'hFFFF_9234);

    // Load flag without a valid instruction must stay off the bus.
    validM = 1'b0; mem2regM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h400;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("novalid_req", {31'd0, bus_req}, 32'd0);
      chk("novalid_stall", {31'd0, stallM}, 32'd0);
      @(posedge clk); #1;
    end
    mem2regM = 1'b0;

    // lw interrupted by reset during its third byte.
    validM = 1'b1; mem2regM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_0040;
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 8'hAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("abort_pre_req", {31'd0, bus_req}, 32'd1);
    chk("abort_pre_addr", bus_addr, 32'h0000_0042);
    reset = 1'b0;
    #1;
    chk("abort_req", {31'd0, bus_req}, 32'd0);
    chk("abort_stall", {31'd0, stallM}, 32'd0);
    chk("abort_we", {31'd0, bus_we}, 32'd0);
    chk("abort_addr", bus_addr, 32'd0);
    chk("abort_wdata", {24'd0, bus_wdata}, 32'd0);
    chk("abort_rdata", readDataM, 32'd0);
    validM = 1'b0; mem2regM = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    runAccess("lw", 1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'd0, 32'h1122_3344,
              0, 4, 5, 32'h1122_3344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
